// File: rtl/mult_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module  : mult_ctrl_pkg
// Purpose : Shared definitions for the HI/LO multiply controller: the
//           state-encoding width and the controller state enumeration.
// Ports   : none (package)
// Config  : MULT_SIGNED_EN (consumed by mult_ctrl, not by this package)
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mult_ctrl_pkg;

  // Width of the controller state register.
  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'd0,  // waiting for a request; HI/LO readable
    ST_LAUNCH = 2'd1,  // one-cycle start pulse to the multiplier
    ST_WAIT   = 2'd2,  // waiting for the multiplier result
    ST_WRITE  = 2'd3   // commit product to HI/LO
  } state_t;

endpackage : mult_ctrl_pkg

`default_nettype wire

// File: rtl/mult_sign_fix.sv
//------------------------------------------------------------------------------
// Module  : mult_sign_fix
// Purpose : Signed-multiply support around an unsigned multiplier. Converts
//           two operands to magnitudes (when signed), reports whether the
//           operand signs differ, and conditionally two's-complement negates
//           the double-width product.
// Ports   : is_signed_i       - operands are two's-complement
//           op_a_i / op_b_i   - raw operands
//           mag_a_o / mag_b_o - operand magnitudes for the multiplier
//           negate_o          - signs differ (product must be negated)
//           negate_i          - registered negate flag for the product path
//           prod_i            - unsigned product of the magnitudes
//           prod_o            - sign-corrected product
// Config  : only instantiated when MULT_SIGNED_EN is defined
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mult_sign_fix #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    is_signed_i,
  input  logic [DATA_WIDTH-1:0]   op_a_i,
  input  logic [DATA_WIDTH-1:0]   op_b_i,
  output logic [DATA_WIDTH-1:0]   mag_a_o,
  output logic [DATA_WIDTH-1:0]   mag_b_o,
  output logic                    negate_o,
  input  logic                    negate_i,
  input  logic [2*DATA_WIDTH-1:0] prod_i,
  output logic [2*DATA_WIDTH-1:0] prod_o
);

  localparam logic [DATA_WIDTH-1:0]   c_one_op   = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*DATA_WIDTH-1:0] c_one_prod = {{(2*DATA_WIDTH-1){1'b0}}, 1'b1};

  logic w_a_neg;
  logic w_b_neg;

  assign w_a_neg = is_signed_i & op_a_i[DATA_WIDTH-1];
  assign w_b_neg = is_signed_i & op_b_i[DATA_WIDTH-1];

  // The most-negative value maps onto itself, which is still the correct
  // unsigned magnitude.
  assign mag_a_o  = w_a_neg ? (~op_a_i + c_one_op) : op_a_i;
  assign mag_b_o  = w_b_neg ? (~op_b_i + c_one_op) : op_b_i;
  assign negate_o = w_a_neg ^ w_b_neg;

  assign prod_o   = negate_i ? (~prod_i + c_one_prod) : prod_i;

endmodule : mult_sign_fix

`default_nettype wire

// File: rtl/mult_ctrl.sv
//------------------------------------------------------------------------------
// Module  : mult_ctrl
// Purpose : HI/LO multiply controller. Accepts MULT/MULTU requests from the
//           core, drives an external sequential unsigned multiplier, writes
//           the product into HI/LO and serves MFHI/MFLO reads, stalling the
//           core while a multiply is in flight.
// Ports   : CLK, RST              - clock, synchronous active-high reset
//           mul_req / mul_signed  - multiply request and signedness
//           rs_val / rt_val       - operands
//           mf_req / mf_sel       - HI/LO read request, 1 = HI, 0 = LO
//           mf_data               - selected HI/LO value
//           stall                 - core must hold its instruction
//           mul_ack               - request accepted (one-cycle pulse)
//           mul_start, mul_op1/2  - to multiplier
//           mul_result, mul_valid - from multiplier
// Config  : MULT_SIGNED_EN - enables signed MULT via magnitude multiply and
//           product negation; otherwise mul_signed is ignored.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mult_ctrl
  import mult_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    mul_req,
  input  logic                    mul_signed,
  input  logic [DATA_WIDTH-1:0]   rs_val,
  input  logic [DATA_WIDTH-1:0]   rt_val,
  input  logic                    mf_req,
  input  logic                    mf_sel,
  output logic [DATA_WIDTH-1:0]   mf_data,
  output logic                    stall,
  output logic                    mul_ack,
  output logic                    mul_start,
  output logic [DATA_WIDTH-1:0]   mul_op1,
  output logic [DATA_WIDTH-1:0]   mul_op2,
  input  logic [2*DATA_WIDTH-1:0] mul_result,
  input  logic                    mul_valid
);

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   op1_q, op1_d;
  logic [DATA_WIDTH-1:0]   op2_q, op2_d;
  logic [2*DATA_WIDTH-1:0] prod_q, prod_d;
  logic [DATA_WIDTH-1:0]   hi_q, hi_d;
  logic [DATA_WIDTH-1:0]   lo_q, lo_d;

  logic [DATA_WIDTH-1:0]   w_mag_a;
  logic [DATA_WIDTH-1:0]   w_mag_b;
  logic [2*DATA_WIDTH-1:0] w_prod_fix;

`ifdef MULT_SIGNED_EN
  logic neg_q, neg_d;
  logic w_neg;

  mult_sign_fix #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_sign_fix (
    .is_signed_i (mul_signed),
    .op_a_i      (rs_val),
    .op_b_i      (rt_val),
    .mag_a_o     (w_mag_a),
    .mag_b_o     (w_mag_b),
    .negate_o    (w_neg),
    .negate_i    (neg_q),
    .prod_i      (prod_q),
    .prod_o      (w_prod_fix)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= neg_d;
    end
  end
`else
  // Unsigned-only build: signedness is ignored entirely.
  logic w_unused_signed;

  assign w_unused_signed = mul_signed;
  assign w_mag_a         = rs_val;
  assign w_mag_b         = rt_val;
  assign w_prod_fix      = prod_q;
`endif

  //--------------------------------------------------------------------------
  // State and datapath registers
  //--------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      op1_q   <= '0;
      op2_q   <= '0;
      prod_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      prod_q  <= prod_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  //--------------------------------------------------------------------------
  // Next-state and output logic
  //--------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    prod_d    = prod_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    mul_ack   = 1'b0;
    mul_start = 1'b0;
`ifdef MULT_SIGNED_EN
    neg_d     = neg_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (mul_req) begin
          mul_ack = 1'b1;
          op1_d   = w_mag_a;
          op2_d   = w_mag_b;
`ifdef MULT_SIGNED_EN
          neg_d   = w_neg;
`endif
          state_d = ST_LAUNCH;
        end
      end

      ST_LAUNCH: begin
        mul_start = 1'b1;
        state_d   = ST_WAIT;
      end

      ST_WAIT: begin
        // Operands stay in op1_q/op2_q, so the multiplier inputs are stable
        // for the whole multiply.
        if (mul_valid) begin
          prod_d  = mul_result;
          state_d = ST_WRITE;
        end
      end

      ST_WRITE: begin
        hi_d    = w_prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
        lo_d    = w_prod_fix[DATA_WIDTH-1:0];
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign mul_op1 = op1_q;
  assign mul_op2 = op2_q;

  // Reads in IDLE see the HI/LO values from before any multiply accepted in
  // the same cycle, since HI/LO only change in WRITE.
  assign mf_data = mf_sel ? hi_q : lo_q;
  assign stall   = (mul_req | mf_req) & (state_q != ST_IDLE);

endmodule : mult_ctrl

`default_nettype wire

// File: tb/tb_mult_ctrl.sv
//------------------------------------------------------------------------------
// Module  : tb_mult_ctrl
// Purpose : Directed self-checking bench for mult_ctrl (DATA_WIDTH = 32).
//           A small in-bench multiplier answers mul_start after a chosen
//           number of cycles.
// Config  : expectations for the signed case follow MULT_SIGNED_EN
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mult_ctrl;

  localparam int W = 32;

  logic          CLK;
  logic          RST;
  logic          mul_req;
  logic          mul_signed;
  logic [W-1:0]  rs_val;
  logic [W-1:0]  rt_val;
  logic          mf_req;
  logic          mf_sel;
  logic [W-1:0]  mf_data;
  logic          stall;
  logic          mul_ack;
  logic          mul_start;
  logic [W-1:0]  mul_op1;
  logic [W-1:0]  mul_op2;
  logic [2*W-1:0] mul_result;
  logic          mul_valid;

  int tests;
  int fails;

  mult_ctrl #(
    .DATA_WIDTH (W)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .mul_req    (mul_req),
    .mul_signed (mul_signed),
    .rs_val     (rs_val),
    .rt_val     (rt_val),
    .mf_req     (mf_req),
    .mf_sel     (mf_sel),
    .mf_data    (mf_data),
    .stall      (stall),
    .mul_ack    (mul_ack),
    .mul_start  (mul_start),
    .mul_op1    (mul_op1),
    .mul_op2    (mul_op2),
    .mul_result (mul_result),
    .mul_valid  (mul_valid)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_hilo(input string tag, input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
    mf_sel = 1'b1;
    #1;
    check({tag, ".hi"}, mf_data, exp_hi);
    mf_sel = 1'b0;
    #1;
    check({tag, ".lo"}, mf_data, exp_lo);
  endtask

  // One complete multiply; starts and ends just after a rising edge with the
  // DUT in IDLE. lat = cycles from the start pulse to mul_valid (>= 1).
  // probe = issue MFHI from the cycle after mul_ack (and MFLO alongside the
  // request) to exercise stall and pre-multiply reads.
  task automatic do_mul(input string tag,
                        input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                        input logic [W-1:0] exp_op1, input logic [W-1:0] exp_op2,
                        input int lat, input logic probe, input logic [W-1:0] prev_lo,
                        input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
    int           starts;
    int           stall_low;
    logic [W-1:0] c1;
    logic [W-1:0] c2;
    starts    = 0;
    stall_low = 0;
    rs_val     = a;
    rt_val     = b;
    mul_signed = sgn;
    mul_req    = 1'b1;
    if (probe) begin
      mf_req = 1'b1;
      mf_sel = 1'b0;
    end
    // IDLE: accept
    @(negedge CLK);
    check({tag, ".ack"}, mul_ack, 1'b1);
    if (probe) check({tag, ".mf_pre"}, mf_data, prev_lo);
    tick();
    mul_req = 1'b0;
    rs_val  = '0;
    rt_val  = '0;
    if (probe) mf_sel = 1'b1;
    // LAUNCH
    @(negedge CLK);
    if (mul_start) starts++;
    if (probe && !stall) stall_low++;
    c1 = mul_op1;
    c2 = mul_op2;
    check({tag, ".op1"}, c1, exp_op1);
    check({tag, ".op2"}, c2, exp_op2);
    tick();
    // WAIT
    for (int i = 0; i < lat - 1; i++) begin
      @(negedge CLK);
      if (mul_start) starts++;
      if (probe && !stall) stall_low++;
      tick();
    end
    mul_valid  = 1'b1;
    mul_result = {{W{1'b0}}, c1} * {{W{1'b0}}, c2};
    @(negedge CLK);
    if (mul_start) starts++;
    if (probe && !stall) stall_low++;
    check({tag, ".op1_hold"}, mul_op1, exp_op1);
    check({tag, ".op2_hold"}, mul_op2, exp_op2);
    tick();
    mul_valid  = 1'b0;
    mul_result = 64'hDEAD_BEEF_0BAD_F00D;
    // WRITE
    @(negedge CLK);
    if (mul_start) starts++;
    if (probe && !stall) stall_low++;
    tick();
    // IDLE with new HI/LO
    @(negedge CLK);
    check({tag, ".starts"}, starts, 1);
    if (probe) begin
      check({tag, ".stall_gap"}, stall_low, 0);
      check({tag, ".stall_idle"}, stall, 1'b0);
      check({tag, ".mf_new_hi"}, mf_data, exp_hi);
      mf_req = 1'b0;
    end
    check_hilo(tag, exp_hi, exp_lo);
    tick();
  endtask

  initial begin
    int           acks;
    int           starts;
    int           pend;
    logic         switched;
    logic [2*W-1:0] pr;

    tests      = 0;
    fails      = 0;
    RST        = 1'b1;
    mul_req    = 1'b0;
    mul_signed = 1'b0;
    rs_val     = '0;
    rt_val     = '0;
    mf_req     = 1'b0;
    mf_sel     = 1'b0;
    mul_result = '0;
    mul_valid  = 1'b0;

    // Reset state
    tick();
    tick();
    RST    = 1'b0;
    mf_req = 1'b1;
    @(negedge CLK);
    check("rst.stall", stall, 1'b0);
    check("rst.ack", mul_ack, 1'b0);
    check("rst.start", mul_start, 1'b0);
    check_hilo("rst", 32'h0, 32'h0);
    mf_req = 1'b0;
    tick();

    // MULTU 11 x 14
    do_mul("multu_small", 32'd11, 32'd14, 1'b0, 32'd11, 32'd14, 2, 1'b0, 32'h0,
           32'h0000_0000, 32'h0000_009A);

    // MULTU all-ones squared, with MFLO alongside the request and MFHI during it
    do_mul("multu_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           1, 1'b1, 32'h0000_009A, 32'hFFFF_FFFE, 32'h0000_0001);

    // MULT -3 x 5
`ifdef MULT_SIGNED_EN
    do_mul("mult_neg", 32'hFFFF_FFFD, 32'd5, 1'b1, 32'd3, 32'd5, 3, 1'b0, 32'h0,
           32'hFFFF_FFFF, 32'hFFFF_FFF1);
`else
    do_mul("mult_neg", 32'hFFFF_FFFD, 32'd5, 1'b1, 32'hFFFF_FFFD, 32'd5, 3, 1'b0, 32'h0,
           32'h0000_0004, 32'hFFFF_FFF1);
`endif

    // Reset during WAIT, then a late mul_valid
    mul_req = 1'b1;
    rs_val  = 32'd7;
    rt_val  = 32'd9;
    tick();                   // LAUNCH
    mul_req = 1'b0;
    tick();                   // WAIT
    RST = 1'b1;
    tick();                   // reset edge taken
    RST        = 1'b0;
    mul_valid  = 1'b1;
    mul_result = 64'h1234_5678_9ABC_DEF0;
    mf_req     = 1'b1;
    @(negedge CLK);
    check("rstwait.stall", stall, 1'b0);
    check("rstwait.start", mul_start, 1'b0);
    check_hilo("rstwait.now", 32'h0, 32'h0);
    tick();
    tick();
    mul_valid = 1'b0;
    mf_req    = 1'b0;
    @(negedge CLK);
    check_hilo("rstwait.late", 32'h0, 32'h0);
    tick();

    // Back-to-back: mul_req held through two multiplies (2x3 then 4x5)
    acks     = 0;
    starts   = 0;
    pend     = 0;
    switched = 1'b0;
    pr       = '0;
    mul_signed = 1'b0;
    rs_val   = 32'd2;
    rt_val   = 32'd3;
    mul_req  = 1'b1;
    for (int cyc = 0; cyc < 16; cyc++) begin
      if (pend != 0) begin
        mul_valid  = 1'b1;
        mul_result = pr;
        pend       = 0;
      end else begin
        mul_valid  = 1'b0;
      end
      if (acks == 1 && !switched) begin
        rs_val   = 32'd4;
        rt_val   = 32'd5;
        switched = 1'b1;
      end
      if (acks >= 2) mul_req = 1'b0;
      @(negedge CLK);
      if (mul_ack) acks++;
      if (mul_start) begin
        starts++;
        pend = 1;
        pr   = {{W{1'b0}}, mul_op1} * {{W{1'b0}}, mul_op2};
      end
      tick();
    end
    mul_valid = 1'b0;
    mul_req   = 1'b0;
    @(negedge CLK);
    check("b2b.acks", acks, 2);
    check("b2b.starts", starts, 2);
    check_hilo("b2b", 32'h0, 32'h0000_0014);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_mult_ctrl

`default_nettype wire

// File: doc/mult_ctrl.md
MULT_CTRL -- requirements
Module: mult_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand width; product width is 2*DATA_WIDTH.
REQ-002 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port mul_req  input  1  core requests MULT/MULTU; held until accepted.
REQ-005 SHALL have port mul_signed  input  1  1 = MULT (signed), 0 = MULTU.
REQ-006 SHALL have ports rs_val, rt_val  input  DATA_WIDTH  operands.
REQ-007 SHALL have port mf_req  input  1  core requests MFHI/MFLO.
REQ-008 SHALL have port mf_sel  input  1  0 = LO, 1 = HI.
REQ-009 SHALL have port mf_data  output  DATA_WIDTH  selected HI/LO value.
REQ-010 SHALL have port stall  output  1  core must hold current instruction.
REQ-011 SHALL have port mul_ack  output  1  one-cycle pulse: mul_req accepted.
REQ-012 SHALL have ports mul_start  output  1, mul_op1/mul_op2  output  DATA_WIDTH  drive the sequential unsigned multiplier.
REQ-013 SHALL have ports mul_result  input  2*DATA_WIDTH, mul_valid  input  1  from the multiplier.

Function
REQ-014 SHALL implement states IDLE, LAUNCH, WAIT, WRITE.
REQ-015 IDLE with mul_req=1 SHALL assert mul_ack combinationally, register operands and sign info, go to LAUNCH.
REQ-016 LAUNCH SHALL assert mul_start for exactly one cycle with mul_op1/mul_op2 stable, then go to WAIT.
REQ-017 WAIT SHALL hold mul_op1/mul_op2 stable; on mul_valid=1 register mul_result, go to WRITE.
REQ-018 WRITE SHALL load HI = upper DATA_WIDTH bits, LO = lower DATA_WIDTH bits of the (sign-corrected) product, go to IDLE.
REQ-019 Latency: mul_ack cycle to HI/LO updated SHALL be 3 + multiplier cycles-to-valid.
REQ-020 stall SHALL equal (mul_req or mf_req) and state != IDLE; mul_ack SHALL be 0 outside IDLE.
REQ-021 mf_data SHALL be combinational from HI/LO per mf_sel, valid whenever stall=0.
REQ-022 mul_req and mf_req together in IDLE: mf_data SHALL return pre-multiply HI/LO; multiply accepted same cycle.
REQ-023 mul_valid outside WAIT SHALL be ignored; mul_start SHALL never assert outside LAUNCH.
REQ-024 Back-to-back requests: a mul_req held through WRITE SHALL be accepted in the following IDLE cycle.

Reset
REQ-025 RST=1 at a clock edge SHALL force IDLE and HI=LO=0, clear operand/product registers; mul_start=0, mul_ack=0, stall=0 while in IDLE with no request.
REQ-026 RST mid-operation SHALL abandon the multiply; a late mul_valid SHALL not update HI/LO.

Configuration
REQ-027 With MULT_SIGNED_EN defined, mul_signed=1 SHALL send operand magnitudes to the multiplier and two's-complement-negate the 2*DATA_WIDTH product in WRITE when operand signs differ.
REQ-028 Without MULT_SIGNED_EN, mul_signed SHALL be ignored; all multiplies unsigned.

Structure
REQ-029 Package mult_ctrl_pkg SHALL hold the state enum and the state-encoding width constant.
REQ-030 Sign handling SHALL live in sub-module mult_sign_fix (magnitude in, conditional negate out), instantiated only under MULT_SIGNED_EN.

Verification
REQ-031 MULTU 11 x 14 (DATA_WIDTH=32) -> mul_start one pulse; after valid, HI=0x00000000, LO=0x0000009A.
REQ-032 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-033 MULT -3 x 5 with MULT_SIGNED_EN -> mul_op1=3, mul_op2=5; HI=0xFFFFFFFF, LO=0xFFFFFFF1; without macro -> unsigned product of 0xFFFFFFFD x 5.
REQ-034 mf_req=1, mf_sel=1 issued in the cycle after mul_ack -> stall=1 every cycle until WRITE completes, then mf_data=new HI.
REQ-035 RST=1 during WAIT, then mul_valid=1 -> state IDLE, HI=LO=0, no write.
REQ-036 mul_req held continuously for two multiplies (2x3, 4x5) -> two mul_ack pulses, final LO=0x14.
